// File: rtl/io_tri_bank.sv
// io_tri_bank: per-channel tristate pad bank with segmented drive ramp-up and synchronized pad input.
// Optional glitch filter on the receive path is enabled by defining IO_GLITCH_FILTER_EN.
module io_tri_bank #(
  parameter int WIDTH       = 8,
  parameter int SEGMENTS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            o,
  input  logic [WIDTH-1:0]            t,
  output logic [WIDTH-1:0]            i,
  output logic [WIDTH-1:0]            ready,
  input  logic [WIDTH-1:0]            pad_i,
  output logic [WIDTH-1:0]            pad_o,
  output logic [WIDTH*SEGMENTS-1:0]   pad_seg_oe_n
);

  typedef enum logic [1:0] {OFF, RAMP, ON} state_e;

  localparam logic [SEGMENTS-1:0] ALL_OFF = '1;

  state_e                 state_q [WIDTH];
  state_e                 state_d [WIDTH];
  logic [SEGMENTS-1:0]    oe_q    [WIDTH];
  logic [SEGMENTS-1:0]    oe_d    [WIDTH];
  logic [SYNC_STAGES-1:0] sync_q  [WIDTH];
  logic [WIDTH-1:0]       ready_q, ready_d, pad_o_q, sync_out;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("io_tri_bank: WIDTH must be 1..32");
  end
  if (SEGMENTS < 1 || SEGMENTS > 16) begin : g_bad_segments
    $error("io_tri_bank: SEGMENTS must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_tri_bank: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("io_tri_bank: FILT_CYCLES must be >= 1");
  end

  // Next state per channel: t low adds one more active segment per cycle, t high drops every segment at once.
  always_comb begin
    for (int c = 0; c < WIDTH; c++) begin
      oe_d[c]    = t[c] ? ALL_OFF :
                   (state_q[c] == ON)  ? '0 :
                   (state_q[c] == OFF) ? ALL_OFF << 1 : oe_q[c] << 1;
      state_d[c] = t[c] ? OFF : (oe_d[c] == '0) ? ON : RAMP;
      ready_d[c] = state_d[c] == ON;
    end
  end

  // Drive-side state, output data register and input synchronizer; reset releases the pads immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < WIDTH; c++) begin
        state_q[c] <= OFF;
        oe_q[c]    <= ALL_OFF;
        sync_q[c]  <= '0;
      end
      ready_q <= '0;
      pad_o_q <= '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        state_q[c] <= state_d[c];
        oe_q[c]    <= oe_d[c];
        sync_q[c]  <= {sync_q[c][SYNC_STAGES-2:0], pad_i[c]};
      end
      ready_q <= ready_d;
      pad_o_q <= o;
    end
  end

  // Last synchronizer stage of each channel.
  always_comb begin
    for (int c = 0; c < WIDTH; c++) sync_out[c] = sync_q[c][SYNC_STAGES-1];
  end

  for (genvar c = 0; c < WIDTH; c++) begin : g_oe
    assign pad_seg_oe_n[c*SEGMENTS +: SEGMENTS] = oe_q[c];
  end

  assign ready = ready_q;
  assign pad_o = pad_o_q;

`ifdef IO_GLITCH_FILTER_EN
  localparam int             CW       = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0]  FILT_MAX = CW'(FILT_CYCLES);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] i_q, i_d;

  // Accept a new input level only after it has persisted for FILT_CYCLES cycles; any agreement restarts the count.
  always_comb begin
    for (int c = 0; c < WIDTH; c++) begin
      cnt_d[c] = '0;
      i_d[c]   = i_q[c];
      if (sync_out[c] != i_q[c]) begin
        if (cnt_q[c] == FILT_MAX - 1'b1) i_d[c] = sync_out[c];
        else cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < WIDTH; c++) cnt_q[c] <= '0;
      i_q <= '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) cnt_q[c] <= cnt_d[c];
      i_q <= i_d;
    end
  end

  assign i = i_q;
`else
  assign i = sync_out;
`endif

endmodule

// File: tb/tb_io_tri_bank.sv
// tb_io_tri_bank: scoreboard bench for io_tri_bank (default parameters; IO_GLITCH_FILTER_EN optional).
module tb_io_tri_bank;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int SS = 2;
  localparam int FC = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     o = '1;
  logic [W-1:0]     t = '0;
  logic [W-1:0]     pad_i = '0;
  logic [W-1:0]     i, ready, pad_o;
  logic [W*S-1:0]   pad_seg_oe_n;

  io_tri_bank #(.WIDTH(W), .SEGMENTS(S), .SYNC_STAGES(SS), .FILT_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .o(o), .t(t), .i(i), .ready(ready),
    .pad_i(pad_i), .pad_o(pad_o), .pad_seg_oe_n(pad_seg_oe_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W*S-1:0] oe;
    logic [W-1:0]   po;
    logic [W-1:0]   rdy;
    logic [W-1:0]   in;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int         seg_cnt [W];
  int         fcnt    [W];
  logic [W-1:0] m_po, p1, p2, fi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < W; c++) begin
      seg_cnt[c] = 0;
      fcnt[c]    = 0;
    end
    m_po = '0;
    p1   = '0;
    p2   = '0;
    fi   = '0;
  endtask

  // Drive one cycle of stimulus, push the predicted post-edge outputs, then pop and compare after the edge.
  task automatic step(input logic [W-1:0] tv, input logic [W-1:0] ov, input logic [W-1:0] pv);
    exp_t e;
    t = tv;
    o = ov;
    pad_i = pv;
    for (int c = 0; c < W; c++) begin
      if (tv[c]) seg_cnt[c] = 0;
      else if (seg_cnt[c] < S) seg_cnt[c]++;
    end
`ifdef IO_GLITCH_FILTER_EN
    for (int c = 0; c < W; c++) begin
      if (p2[c] != fi[c]) begin
        fcnt[c]++;
        if (fcnt[c] == FC) begin
          fi[c]   = p2[c];
          fcnt[c] = 0;
        end
      end else fcnt[c] = 0;
    end
`endif
    p2   = p1;
    p1   = pv;
    m_po = ov;
    for (int c = 0; c < W; c++) begin
      for (int s = 0; s < S; s++) e.oe[c*S+s] = (s >= seg_cnt[c]);
      e.rdy[c] = (seg_cnt[c] == S);
    end
    e.po = m_po;
`ifdef IO_GLITCH_FILTER_EN
    e.in = fi;
`else
    e.in = p2;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_oe", pad_seg_oe_n, e.oe);
    chk("sb_pad_o", pad_o, e.po);
    chk("sb_ready", ready, e.rdy);
    chk("sb_i", i, e.in);
  endtask

  logic [3:0] ramp_tbl [4];
  int lat;

  initial begin
    ramp_tbl = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    model_reset();
    #12;
    chk("rst_oe", pad_seg_oe_n, {W*S{1'b1}});
    chk("rst_pad_o", pad_o, 0);
    chk("rst_ready", ready, 0);
    chk("rst_i", i, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step('0, 8'hFF, '0);
      if (ready[0]) lat = k;
    end
    chk("ready_latency", lat, S);

    step('1, 8'h00, '0);
    step('1, 8'h5A, '0);
    for (int k = 0; k < 4; k++) begin
      step(8'hFB, 8'hA5, '0);
      chk("ramp_ch2", pad_seg_oe_n[11:8], ramp_tbl[k]);
      chk("ramp_ready2", ready[2], k == 3);
    end

    step('1, 8'h3C, '0);
    step(8'hFD, 8'hC3, '0);
    step(8'hFD, 8'h11, '0);
    step('1, 8'h22, '0);
    chk("abort_oe1", pad_seg_oe_n[7:4], 4'b1111);
    chk("abort_ready1", ready[1], 0);
    step(8'hFD, 8'h33, '0);
    chk("restart_oe1", pad_seg_oe_n[7:4], 4'b1110);

    for (int k = 0; k < 8; k++) step('1, 8'h00, '0);
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      step('1, 8'h00, 8'h08);
      if (i[3]) lat = k;
    end
`ifdef IO_GLITCH_FILTER_EN
    chk("in_latency", lat, SS + FC);
`else
    chk("in_latency", lat, SS);
`endif
    for (int k = 0; k < 8; k++) step('1, 8'h00, '0);
    step('1, 8'h00, 8'h08);
    for (int k = 0; k < 4; k++) step('1, 8'h00, '0);
    step('1, 8'h00, 8'h08);
    step('1, 8'h00, 8'h08);
    for (int k = 0; k < 8; k++) step('1, 8'h00, '0);

    for (int k = 0; k < 120; k++) begin
      logic [W-1:0] tv;
      for (int c = 0; c < W; c++) tv[c] = ($urandom_range(0, 4) == 0);
      step(tv, W'($urandom), W'($urandom));
    end

    for (int k = 0; k < S + 1; k++) step('0, 8'h96, '0);
    chk("all_on", ready, {W{1'b1}});
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_oe", pad_seg_oe_n, {W*S{1'b1}});
    chk("arst_ready", ready, 0);
    chk("arst_pad_o", pad_o, 0);
    chk("arst_i", i, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_hold_oe", pad_seg_oe_n, {W*S{1'b1}});
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step(W'($urandom) & W'($urandom), W'($urandom), W'($urandom));

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
